// File: rtl/sub_seq_pkg.sv
// Shared types and constants for the sequential CLA subtractor.
package sub_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  localparam int unsigned DefWidth  = 16;
  localparam int unsigned DefSlice  = 4;
  localparam int unsigned DefNSlice = DefWidth / DefSlice;

  // Width of a counter/index able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sub_seq_cla_if.sv
// Operand/result handshake bundle for sub_seq_cla.
interface sub_seq_cla_if
  import sub_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             overflow;
  logic             zero;

  // Source of operands and consumer of results.
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, overflow, zero
  );

  // The subtractor itself.
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, overflow, zero
  );

endinterface

// File: rtl/cla_slice.sv
// Combinational N-bit carry-lookahead adder slice; exposes every internal carry.
module cla_slice #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic [N:0]   c
);

  logic [N-1:0] g;
  logic [N-1:0] p;

  // Generate/propagate and lookahead carries; the recurrence flattens to sum-of-products.
  always_comb begin
    g    = x & y;
    p    = x | y;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(N); i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum = x ^ y ^ c[N-1:0];
  end

endmodule

// File: rtl/sub_seq_cla.sv
// Multi-cycle subtractor: a - b - bin, one SLICE-bit CLA slice per cycle.
module sub_seq_cla
  import sub_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned SLICE = DefSlice
) (
  input  logic            clk,
  input  logic            rst,
  sub_seq_cla_if.slave    bus
);

  localparam int unsigned NSlice = WIDTH / SLICE;
  localparam int unsigned CntW   = cnt_width(NSlice);
  localparam int unsigned IdxW   = cnt_width(WIDTH);

  if ((SLICE == 0) || ((WIDTH % SLICE) != 0)) begin : g_bad_cfg
    $error("sub_seq_cla: WIDTH must be a non-zero multiple of SLICE");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             c_q, c_d;
  logic [CntW-1:0]  k_q, k_d;
  logic             out_valid_q, out_valid_d;
  logic             bout_q, bout_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic [IdxW-1:0]  base;
  logic [SLICE-1:0] x_k;
  logic [SLICE-1:0] y_k;
  logic [SLICE-1:0] sum_k;
  logic [SLICE:0]   carries;
  logic             last;

  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

  // Select the operand bits for the slice currently being processed.
  always_comb begin
    base = IdxW'(k_q) * IdxW'(SLICE);
    x_k  = a_q[base +: SLICE];
    y_k  = nb_q[base +: SLICE];
    last = (k_q == CntW'(NSlice - 1));
  end

  // Single shared slice; subtraction is a + ~b + ~bin.
  cla_slice #(
    .N (SLICE)
  ) u_slice (
    .x   (x_k),
    .y   (y_k),
    .cin (c_q),
    .sum (sum_k),
    .c   (carries)
  );

  // Next-state logic for the IDLE -> BUSY -> DONE sequence and registered outputs.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    nb_d        = nb_q;
    diff_d      = diff_q;
    c_d         = c_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    bout_d      = bout_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && bus.in_ready) begin
          a_d     = bus.a;
          nb_d    = ~bus.b;
          c_d     = ~bus.bin;
          k_d     = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        diff_d[base +: SLICE] = sum_k;
        c_d = carries[SLICE];
        k_d = k_q + CntW'(1);
        if (last) begin
          // Carry out of the adder form is the inverse of the borrow.
          bout_d      = ~carries[SLICE];
          overflow_d  = carries[SLICE] ^ carries[SLICE-1];
          zero_d      = (diff_d == '0);
          out_valid_d = 1'b1;
          k_d         = '0;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      nb_q        <= '0;
      diff_q      <= '0;
      c_q         <= 1'b0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      bout_q      <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      nb_q        <= nb_d;
      diff_q      <= diff_d;
      c_q         <= c_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      bout_q      <= bout_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

endmodule

// File: tb/tb_sub_seq_cla.sv
// Scoreboard bench for sub_seq_cla with directed, hand-computed vectors.
module tb_sub_seq_cla;

  localparam int NS = 4;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        ov;
    logic        zero;
    int          exp_cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t cur;
  bit   have_cur = 1'b0;

  sub_seq_cla_if #(.WIDTH(16)) bus ();

  sub_seq_cla #(
    .WIDTH (16),
    .SLICE (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [15:0] d, input logic b, input logic o, input logic z);
    exp_t e;
    e.diff    = d;
    e.bout    = b;
    e.ov      = o;
    e.zero    = z;
    e.exp_cyc = cyc + 1 + NS;
    q.push_back(e);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bin,
                      input logic [15:0] d, input logic eb, input logic eo, input logic ez);
    int n = 0;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      chk("accept timeout", 32'(bus.in_ready), 32'd1);
    end else begin
      push_exp(d, eb, eo, ez);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q.size() != 0 || have_cur || !bus.in_ready) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("result timeout", 32'(q.size()), 32'd0);
  endtask

  // Monitor: compare each presented result against the scoreboard, and its hold while stalled.
  always @(negedge clk) begin
    if (rst) begin
      have_cur = 1'b0;
    end else if (bus.out_valid) begin
      if (!have_cur) begin
        if (q.size() == 0) begin
          chk("unexpected out_valid", 32'd1, 32'd0);
        end else begin
          cur = q.pop_front();
          have_cur = 1'b1;
          chk("latency", cyc, cur.exp_cyc);
        end
      end
      if (have_cur) begin
        chk("diff", 32'(bus.diff), 32'(cur.diff));
        chk("bout", 32'(bus.bout), 32'(cur.bout));
        chk("overflow", 32'(bus.overflow), 32'(cur.ov));
        chk("zero", 32'(bus.zero), 32'(cur.zero));
        if (bus.out_ready) have_cur = 1'b0;
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("in_ready in reset", 32'(bus.in_ready), 32'd0);
    chk("out_valid in reset", 32'(bus.out_valid), 32'd0);
    chk("diff in reset", 32'(bus.diff), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("in_ready after reset", 32'(bus.in_ready), 32'd1);

    send(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    wait_done();
    send(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    wait_done();
    send(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    wait_done();
    send(16'h5555, 16'h5555, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    wait_done();
    send(16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    wait_done();

    // Backpressure with a competing operand pair held on the input.
    bus.out_ready = 1'b0;
    send(16'h00FF, 16'h0F00, 1'b0, 16'hF1FF, 1'b1, 1'b0, 1'b0);
    begin
      int n = 0;
      while (!bus.out_valid && n < 20) begin
        tick();
        n++;
      end
      chk("bp out_valid rise", 32'(bus.out_valid), 32'd1);
    end
    bus.a        = 16'h0003;
    bus.b        = 16'h0001;
    bus.bin      = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp out_valid held", 32'(bus.out_valid), 32'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp out_valid drop", 32'(bus.out_valid), 32'd0);
    chk("bp in_ready back", 32'(bus.in_ready), 32'd1);
    push_exp(16'h0002, 1'b0, 1'b0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    wait_done();

    // Reset while slice 2 is pending.
    send(16'h1234, 16'h1111, 1'b0, 16'h0123, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    q.delete();
    tick();
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst diff", 32'(bus.diff), 32'd0);
    chk("rst flags", {29'd0, bus.bout, bus.overflow, bus.zero}, 32'd0);
    chk("rst in_ready low", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", 32'(bus.in_ready), 32'd1);
    send(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);
    wait_done();
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
